// File: rtl/fetch_buffer.sv
// Fetch front end: sysbus line reads split into an instruction FIFO for the decoder.
// Define FETCH_TRACE_EN to print every pushed instruction and the halt event.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 entry,
  output logic                        bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic                        bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
  output logic                        bus_respack,
  input  logic                        redirect_valid,
  input  logic [63:0]                 redirect_pc,
  output logic [BUS_DATA_WIDTH/2-1:0] inst,
  output logic [63:0]                 inst_pc,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic                        halted
);

  localparam int IW     = BUS_DATA_WIDTH / 2;
  localparam int BBYTES = BUS_DATA_WIDTH / 8;
  localparam int NBEATS = 64 / BBYTES;
  localparam int BW     = $clog2(NBEATS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [63:0] LINE_MASK = ~64'h3f;
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
    (BUS_TAG_WIDTH'(`SYSBUS_READ) << 12) |
    (BUS_TAG_WIDTH'(`SYSBUS_MEMORY) << 8);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    HALT
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [63:0]     line_addr_q, line_addr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            drop_q, drop_d;
  logic            zero_q, zero_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [IW-1:0]   inst_mem_q [FIFO_DEPTH];
  logic [63:0]     pc_mem_q   [FIFO_DEPTH];

  logic            beat_fire, last_beat, room;
  logic [63:0]     pc_lo, pc_hi;
  logic [IW-1:0]   w_lo, w_hi;
  logic            keep_lo, keep_hi;
  logic            zero_lo, zero_hi;
  logic            push_lo, push_hi;
  logic [1:0]      npush;
  logic            pop;
  logic            we0, we1;
  logic [IW-1:0]   wd0_inst;
  logic [63:0]     wd0_pc;
  logic [PW-1:0]   wr_nx;
  logic            unused_tag;

  assign unused_tag  = ^bus_resptag;
  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = BUS_DATA_WIDTH'(line_addr_q);
  assign bus_reqtag  = REQ_TAG;
  assign bus_respack = (state_q == BURST) & bus_respcyc;
  assign halted      = (state_q == HALT);
  assign inst_valid  = (count_q != '0);
  assign inst        = inst_mem_q[rd_q];
  assign inst_pc     = pc_mem_q[rd_q];

  assign beat_fire = bus_respack;
  assign last_beat = beat_fire & (beat_q == BW'(NBEATS - 1));
  assign room      = (count_q <= CW'(FIFO_DEPTH - 16));

  assign pc_lo = line_addr_q + (64'(beat_q) * 64'(BBYTES));
  assign pc_hi = pc_lo + 64'(IW / 8);
  assign w_lo  = bus_resp[IW-1:0];
  assign w_hi  = bus_resp[BUS_DATA_WIDTH-1:IW];

  // Slots behind fetch_pc or in a dropped burst are never zero-checked.
  always_comb begin
    keep_lo = beat_fire & ~drop_q & ~zero_q &
              (pc_lo >= fetch_pc_q);
    zero_lo = keep_lo & (w_lo == '0);
    keep_hi = beat_fire & ~drop_q & ~zero_q & ~zero_lo &
              (pc_hi >= fetch_pc_q);
    zero_hi = keep_hi & (w_hi == '0);
    push_lo = keep_lo & ~zero_lo & ~redirect_valid;
    push_hi = keep_hi & ~zero_hi & ~redirect_valid;
    npush   = {1'b0, push_lo} + {1'b0, push_hi};
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    line_addr_d = line_addr_q;
    beat_d      = beat_q;
    drop_d      = drop_q;
    zero_d      = zero_q;
    unique case (state_q)
      IDLE: if (room) state_d = REQ;
      REQ:  if (bus_reqack) state_d = BURST;
      BURST: begin
        if (beat_fire) begin
          beat_d = beat_q + 1'b1;
          zero_d = zero_q | zero_lo | zero_hi;
          if (last_beat) begin
            state_d = IDLE;
            drop_d  = 1'b0;
            zero_d  = 1'b0;
            if (drop_q) begin
              line_addr_d = fetch_pc_q & LINE_MASK;
            end else if (zero_q | zero_lo | zero_hi) begin
              state_d = HALT;
            end else begin
              line_addr_d = line_addr_q + 64'd64;
              fetch_pc_d  = line_addr_q + 64'd64;
            end
          end
        end
      end
      default: ;
    endcase
    // The bus transaction in flight always completes; only its data is dropped.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      unique case (state_q)
        REQ: drop_d = 1'b1;
        BURST: begin
          if (last_beat) begin
            state_d     = IDLE;
            drop_d      = 1'b0;
            line_addr_d = redirect_pc & LINE_MASK;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          line_addr_d = redirect_pc & LINE_MASK;
        end
      endcase
    end
  end

  always_comb begin
    pop      = inst_valid & inst_ready & ~redirect_valid;
    we0      = push_lo | push_hi;
    we1      = push_lo & push_hi;
    wd0_inst = push_lo ? w_lo : w_hi;
    wd0_pc   = push_lo ? pc_lo : pc_hi;
    wr_nx    = wr_q + 1'b1;
    if (redirect_valid) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = rd_q + PW'(pop);
      wr_d    = wr_q + PW'(npush);
      count_d = count_q + CW'(npush) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= entry;
      line_addr_q <= entry & LINE_MASK;
      beat_q      <= '0;
      drop_q      <= 1'b0;
      zero_q      <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      line_addr_q <= line_addr_d;
      beat_q      <= beat_d;
      drop_q      <= drop_d;
      zero_q      <= zero_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) begin
      inst_mem_q[wr_q] <= wd0_inst;
      pc_mem_q[wr_q]   <= wd0_pc;
    end
    if (we1) begin
      inst_mem_q[wr_nx] <= w_hi;
      pc_mem_q[wr_nx]   <= pc_hi;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_lo) $display("%h %h", pc_lo, w_lo);
      if (push_hi) $display("%h %h", pc_hi, w_hi);
      if (state_q != HALT && state_d == HALT)
        $display("fetch halted");
    end
  end
`endif

endmodule
